hazard_sequencer: RTL and testbench

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_pkg.sv | 14 +
 rtl/tick_gen.sv | 34 +++
 rtl/hazard_sequencer.sv | 105 ++++++++++
 tb/tb_hazard_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard lamp sequencer.
package hazard_pkg;

  localparam int unsigned MODE_W    = 2;
  localparam int unsigned MAX_LAMPS = 32;

  typedef enum logic [MODE_W-1:0] {
    CALM   = 2'b00,
    UP     = 2'b01,
    DOWN   = 2'b10,
    STEADY = 2'b11
  } mode_e;

endpackage

// File: rtl/tick_gen.sv
// Pattern-step tick generator: one tick every TICK_DIV non-held cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int unsigned       CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!hold) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard lamp sequencer: lamp register is the pattern state, stepped on each tick
// according to the latched mode.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_LAMPS = 3,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MODE_W-1:0]    mode,
  input  logic                 hold,
  output logic [NUM_LAMPS-1:0] lamps,
  output logic                 wrap
);

  localparam logic [NUM_LAMPS-1:0] OUTER   = {1'b1, {(NUM_LAMPS-2){1'b0}}, 1'b1};
  localparam logic [NUM_LAMPS-1:0] INNER   = ~OUTER;
  localparam logic [NUM_LAMPS-1:0] ONE_LSB = {{(NUM_LAMPS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LAMPS-1:0] ONE_MSB = {1'b1, {(NUM_LAMPS-1){1'b0}}};

  logic [NUM_LAMPS-1:0] lamps_q, lamps_d;
  mode_e                mode_q, mode_d;
  logic                 wrap_q, wrap_d;
  logic                 tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .tick  (tick)
  );

  function automatic logic [NUM_LAMPS-1:0] start_pattern(input mode_e m);
    case (m)
      CALM:    return INNER;
      UP:      return ONE_LSB;
      DOWN:    return ONE_MSB;
      default: return '1;
    endcase
  endfunction

  function automatic logic is_legal(input mode_e m, input logic [NUM_LAMPS-1:0] p);
    logic onehot;
    onehot = (p != '0) && ((p & (p - ONE_LSB)) == '0);
    case (m)
      CALM:    return (p == OUTER) || (p == INNER);
      UP,
      DOWN:    return onehot;
      default: return p == '1;
    endcase
  endfunction

  // tick is only ever high when hold is low, so hold freezing falls out of the defaults.
  always_comb begin
    lamps_d = lamps_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    if (tick) begin
      if (mode_e'(mode) != mode_q) begin
        mode_d  = mode_e'(mode);
        lamps_d = start_pattern(mode_e'(mode));
      end else if (!is_legal(mode_q, lamps_q)) begin
        lamps_d = start_pattern(mode_q);
      end else begin
        case (mode_q)
          CALM:    lamps_d = (lamps_q == OUTER) ? INNER : OUTER;
          UP: begin
            if (lamps_q[NUM_LAMPS-1]) begin
              lamps_d = ONE_LSB;
              wrap_d  = 1'b1;
            end else begin
              lamps_d = lamps_q << 1;
            end
          end
          DOWN: begin
            if (lamps_q[0]) begin
              lamps_d = ONE_MSB;
              wrap_d  = 1'b1;
            end else begin
              lamps_d = lamps_q >> 1;
            end
          end
          default: lamps_d = '1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lamps_q <= OUTER;
      mode_q  <= CALM;
      wrap_q  <= 1'b0;
    end else begin
      lamps_q <= lamps_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  assign lamps = lamps_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed vector table, hand sequences and random
// stimulus, two instances (TICK_DIV=4 and TICK_DIV=1) against an index-based model.
module tb_hazard_sequencer;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold;
  logic [1:0] mode;
  logic [N-1:0] lamps_a, lamps_b;
  logic       wrap_a, wrap_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.NUM_LAMPS(N), .TICK_DIV(4)) dut_a (
    .clk(clk), .reset(rst), .mode(mode), .hold(hold), .lamps(lamps_a), .wrap(wrap_a)
  );

  hazard_sequencer #(.NUM_LAMPS(N), .TICK_DIV(1)) dut_b (
    .clk(clk), .reset(rst), .mode(mode), .hold(hold), .lamps(lamps_b), .wrap(wrap_b)
  );

  // Model: mode number, lit-lamp index for sweeps, calm phase, cycle count since tick.
  int m_mode[2], m_pos[2], m_phase[2], m_cnt[2];
  bit m_wrap[2];
  int m_td[2] = '{4, 1};

  function automatic logic [N-1:0] model_lamps(input int k);
    int v;
    case (m_mode[k])
      0:       v = (m_phase[k] == 1) ? ((1 << N) - 1) & ~(1 | (1 << (N-1))) : (1 | (1 << (N-1)));
      1, 2:    v = 1 << m_pos[k];
      default: v = (1 << N) - 1;
    endcase
    return v[N-1:0];
  endfunction

  task automatic model_step(input int k, input logic r, input logic h, input logic [1:0] m);
    m_wrap[k] = 1'b0;
    if (r) begin
      m_mode[k] = 0; m_phase[k] = 0; m_cnt[k] = 0; m_pos[k] = 0;
    end else if (!h) begin
      if (m_cnt[k] == m_td[k] - 1) begin
        m_cnt[k] = 0;
        if (int'(m) != m_mode[k]) begin
          m_mode[k] = int'(m);
          m_phase[k] = 1;
          m_pos[k] = (m == 2'd2) ? N - 1 : 0;
        end else begin
          case (m_mode[k])
            0: m_phase[k] = 1 - m_phase[k];
            1: if (m_pos[k] == N - 1) begin m_pos[k] = 0; m_wrap[k] = 1'b1; end
               else m_pos[k] = m_pos[k] + 1;
            2: if (m_pos[k] == 0) begin m_pos[k] = N - 1; m_wrap[k] = 1'b1; end
               else m_pos[k] = m_pos[k] - 1;
            default: ;
          endcase
        end
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic h, input logic [1:0] m);
    rst = r; hold = h; mode = m;
    @(posedge clk);
    model_step(0, r, h, m);
    model_step(1, r, h, m);
    #1;
    check("model_lamps_div4", 32'(lamps_a), 32'(model_lamps(0)));
    check("model_wrap_div4",  32'(wrap_a),  32'(m_wrap[0]));
    check("model_lamps_div1", 32'(lamps_b), 32'(model_lamps(1)));
    check("model_wrap_div1",  32'(wrap_b),  32'(m_wrap[1]));
  endtask

  typedef struct {
    logic       rst;
    logic       hold;
    logic [1:0] mode;
    int         ncyc;
    logic [N-1:0] lamps;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic       r, h;
    logic [1:0] md;

    rst = 1'b1; hold = 1'b0; mode = 2'd0;

    // Reset/CALM timing, UP sweep with wrap, then DOWN load mid-sweep.
    vecs.push_back('{1'b1, 1'b0, 2'd0, 1, 5'b10001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 3, 5'b10001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 1, 5'b01110, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 4, 5'b10001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 4, 5'b00001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 4, 5'b00010, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 4, 5'b00100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 4, 5'b01000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 4, 5'b10000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 4, 5'b00001, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 1, 5'b00001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 3, 5'b00010, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd1, 4, 5'b00100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 4, 5'b10000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 4, 5'b01000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 4, 5'b00100, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 4, 5'b00010, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 4, 5'b00001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 4, 5'b10000, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'd2, 1, 5'b10000, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].ncyc; c++) cycle(vecs[i].rst, vecs[i].hold, vecs[i].mode);
      check($sformatf("vec%0d_lamps", i), 32'(lamps_a), 32'(vecs[i].lamps));
      check($sformatf("vec%0d_wrap", i),  32'(wrap_a),  32'(vecs[i].wrap));
    end

    // Hold for 10 cycles mid-UP at 00010, two cycles into the tick period.
    cycle(1'b1, 1'b0, 2'd1);
    for (int c = 0; c < 8; c++) cycle(1'b0, 1'b0, 2'd1);
    check("hold_pre", 32'(lamps_a), 32'(5'b00010));
    cycle(1'b0, 1'b0, 2'd1);
    cycle(1'b0, 1'b0, 2'd1);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b1, 2'd1);
      check("hold_lamps", 32'(lamps_a), 32'(5'b00010));
      check("hold_wrap",  32'(wrap_a),  32'(1'b0));
    end
    cycle(1'b0, 1'b0, 2'd1);
    check("hold_release_wait", 32'(lamps_a), 32'(5'b00010));
    cycle(1'b0, 1'b0, 2'd1);
    check("hold_release_step", 32'(lamps_a), 32'(5'b00100));

    // Mode glitch between ticks is ignored.
    cycle(1'b0, 1'b0, 2'd3);
    cycle(1'b0, 1'b0, 2'd1);
    cycle(1'b0, 1'b0, 2'd1);
    check("glitch_no_change", 32'(lamps_a), 32'(5'b00100));
    cycle(1'b0, 1'b0, 2'd1);
    check("glitch_up_step", 32'(lamps_a), 32'(5'b01000));

    // Reset with hold at 01000, then TICK_DIV=1 instance alternates each cycle.
    cycle(1'b1, 1'b1, 2'd1);
    check("rst_hold_lamps", 32'(lamps_a), 32'(5'b10001));
    check("rst_hold_wrap",  32'(wrap_a),  32'(1'b0));
    cycle(1'b0, 1'b0, 2'd0);
    check("div1_step1", 32'(lamps_b), 32'(5'b01110));
    cycle(1'b0, 1'b0, 2'd0);
    check("div1_step2", 32'(lamps_b), 32'(5'b10001));
    check("div4_still_outer", 32'(lamps_a), 32'(5'b10001));
    cycle(1'b0, 1'b0, 2'd0);
    cycle(1'b0, 1'b0, 2'd0);
    check("div4_calm_step", 32'(lamps_a), 32'(5'b01110));

    // Random traffic against the model.
    md = 2'd0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(63) == 0);
      h = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) md = 2'($urandom_range(3));
      cycle(r, h, md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
